fifo_sync: RTL and testbench

Synchronous FIFO with the full status-flag set (almost_full, almost_empty, fifo_empty, Fifo_full, fifo_error, fifo_pause) consumed by the data-flow controller. The controller drives write/read; this block stores words, returns read data with one-cycle latency, and reports occupancy and protocol violations back to it. It is one lane of the switch datapath; two instances sit behind each controller.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_mem.sv | 46 ++++
 rtl/fifo_sync.sv | 165 ++++++++++++++++
 tb/tb_fifo_sync.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the fifo_sync lane buffer.
// Holds default geometry, occupancy thresholds, the back-pressure FSM
// state encoding and the per-cycle request decode structure.

package fifo_pkg;

   localparam int FIFO_DATA_WIDTH_DEF   = 6;
   localparam int FIFO_ADDR_WIDTH_DEF   = 2;
   localparam int FIFO_ALMOST_FULL_DEF  = 3;
   localparam int FIFO_ALMOST_EMPTY_DEF = 1;

   // Back-pressure FSM; encoding is visible to the controller via fifo_pause.
   typedef enum logic {
      RUN   = 1'b0,
      PAUSE = 1'b1
   } pause_state_e;

   // One cycle's worth of decoded controller requests.
   typedef struct packed {
      logic push;
      logic pop;
      logic overflow;
      logic underflow;
   } fifo_req_t;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array for fifo_sync.
// One write port and one registered read port. The read register clears
// on reset and otherwise holds its value until the next read enable.
// When read and write address match in the same cycle, the read returns
// the word stored before this edge (the oldest entry of a full FIFO).

module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Array contents need no reset: pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read port, held between accepted pops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO lane with occupancy flags, hysteretic
// back-pressure (fifo_pause) and overflow/underflow reporting.
// Build option FIFO_ERROR_STICKY_EN: when defined fifo_error latches until
// reset; when undefined it pulses for one cycle after each violation.
//
// Pause FSM states:
//   state | meaning
//   RUN   | controller may push freely, fifo_pause = 0
//   PAUSE | occupancy reached ALMOST_FULL_LVL, held until it drains to
//         | ALMOST_EMPTY_LVL or below, fifo_pause = 1

module fifo_sync
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH       = FIFO_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH       = FIFO_ADDR_WIDTH_DEF,
   parameter int ALMOST_FULL_LVL  = FIFO_ALMOST_FULL_DEF,
   parameter int ALMOST_EMPTY_LVL = FIFO_ALMOST_EMPTY_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic                  read,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  fifo_empty,
   output logic                  Fifo_full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  fifo_pause,
   output logic                  fifo_error
);

   localparam int                  DEPTH    = fifo_depth(ADDR_WIDTH);
   localparam int                  CNT_W    = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]    CNT_AF   = CNT_W'(ALMOST_FULL_LVL);
   localparam logic [CNT_W-1:0]    CNT_AE   = CNT_W'(ALMOST_EMPTY_LVL);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [1:0]            rst_sync_q;
   logic                  rst_n;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  valid_q;
   logic                  error_q, error_d;
   pause_state_e          state_q;
   logic                  pause_q;
   fifo_req_t             req;

   // Reset asserts asynchronously, releases two clocks after the pin rises.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   // Status flags decode the registered occupancy.
   assign fifo_empty   = (count_q == '0);
   assign Fifo_full    = (count_q == CNT_FULL);
   assign almost_empty = (count_q <= CNT_AE);
   assign almost_full  = (count_q >= CNT_AF);

   // Accept/reject decision. A pop frees the slot a same-cycle push needs,
   // but a push into an empty FIFO never feeds a same-cycle pop.
   always_comb begin
      req           = '0;
      req.pop       = read && !fifo_empty;
      req.push      = write && (!Fifo_full || req.pop);
      req.overflow  = write && Fifo_full && !req.pop;
      req.underflow = read && fifo_empty;
   end

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (req.push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (req.pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({req.push, req.pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Error flag next value; sticky build accumulates until reset.
`ifdef FIFO_ERROR_STICKY_EN
   assign error_d = error_q | req.overflow | req.underflow;
`else
   assign error_d = req.overflow | req.underflow;
`endif

   // Pointer, count, valid and error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= req.pop;
         error_q  <= error_d;
      end
   end

   // Hysteretic back-pressure FSM, stepping on the same edge as count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pause_q <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (count_d >= CNT_AF) begin
                  state_q <= PAUSE;
                  pause_q <= 1'b1;
               end
            end
            PAUSE: begin
               if (count_d <= CNT_AE) begin
                  state_q <= RUN;
                  pause_q <= 1'b0;
               end
            end
         endcase
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wr_en_i   (req.push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (data_in),
      .rd_en_i   (req.pop),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (data_out)
   );

   assign valid_out  = valid_q;
   assign fifo_pause = pause_q;
   assign fifo_error = error_q;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: scoreboard bench for fifo_sync (default 6-bit x 4 deep).
// Accepted pushes enter a content model; each accepted pop moves the
// model's head word onto an expected-output queue, which is popped and
// compared when the DUT presents valid_out.

module tb_fifo_sync;

   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic       clk;
   logic       reset;
   logic       write;
   logic       read;
   logic [5:0] data_in;
   logic [5:0] data_out;
   logic       valid_out;
   logic       fifo_empty;
   logic       Fifo_full;
   logic       almost_empty;
   logic       almost_full;
   logic       fifo_pause;
   logic       fifo_error;

   fifo_sync dut (
      .clk          (clk),
      .reset        (reset),
      .write        (write),
      .read         (read),
      .data_in      (data_in),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .fifo_empty   (fifo_empty),
      .Fifo_full    (Fifo_full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .fifo_pause   (fifo_pause),
      .fifo_error   (fifo_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {valid_out, fifo_empty, Fifo_full, almost_empty, almost_full, fifo_pause, fifo_error}
   logic [6:0] dut_st;
   assign dut_st = {valid_out, fifo_empty, Fifo_full, almost_empty,
                    almost_full, fifo_pause, fifo_error};

   int         n_vec = 0;
   int         n_err = 0;

   logic [5:0] m_q[$];
   logic [5:0] exp_q[$];
   logic       m_valid;
   logic       m_pause;
   logic       m_err;

   function automatic logic [6:0] model_status();
      int n;
      n = m_q.size();
      return {m_valid, n == 0, n == DEPTH, n <= AE, n >= AF, m_pause, m_err};
   endfunction

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_pause = 1'b0;
      m_err   = 1'b0;
   endtask

   // Drive one cycle of requests, advance the model, sample 1ns after the edge.
   task automatic step(input logic w, input logic r, input logic [5:0] d);
      logic pop_ok, push_ok, viol;
      int   nxt;
      write   = w;
      read    = r;
      data_in = d;
      pop_ok  = r && (m_q.size() != 0);
      push_ok = w && ((m_q.size() != DEPTH) || pop_ok);
      viol    = (w && (m_q.size() == DEPTH) && !pop_ok) || (r && (m_q.size() == 0));
      if (pop_ok)  exp_q.push_back(m_q.pop_front());
      if (push_ok) m_q.push_back(d);
      m_valid = pop_ok;
      nxt = m_q.size();
      if (!m_pause && nxt >= AF)     m_pause = 1'b1;
      else if (m_pause && nxt <= AE) m_pause = 1'b0;
`ifdef FIFO_ERROR_STICKY_EN
      m_err = m_err | viol;
`else
      m_err = viol;
`endif
      @(posedge clk);
      #1;
      write = 1'b0;
      read  = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      model_reset();
      #3;
      n_vec++;
      if (dut_st !== 7'b0101000) begin
         n_err++;
         $display("FAIL reset_status: got %b want %b", dut_st, 7'b0101000);
      end
      n_vec++;
      if (data_out !== 6'h00) begin
         n_err++;
         $display("FAIL reset_data: got %h want 00", data_out);
      end
      release_reset();
      n_vec++;
      if (dut_st !== model_status()) begin
         n_err++;
         $display("FAIL post_reset_status: got %b want %b", dut_st, model_status());
      end
   endtask

   task automatic test_fill_drain();
      logic [5:0] exp;
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0, 6'(i));
         n_vec++;
         if (dut_st !== model_status()) begin
            n_err++;
            $display("FAIL fill_status[%0d]: got %b want %b", i, dut_st, model_status());
         end
      end
      n_vec++;
      if (dut_st !== 7'b0010110) begin
         n_err++;
         $display("FAIL fill_full_flags: got %b want %b", dut_st, 7'b0010110);
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, 6'h00);
         n_vec++;
         if (dut_st !== model_status()) begin
            n_err++;
            $display("FAIL drain_status[%0d]: got %b want %b", i, dut_st, model_status());
         end
         if (m_valid) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (data_out !== exp) begin
               n_err++;
               $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, exp);
            end
         end
         if (i == 3) begin
            n_vec++;
            if (fifo_pause !== 1'b0) begin
               n_err++;
               $display("FAIL drain_pause_clear: got %b want 0", fifo_pause);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [5:0] exp;
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 6'(i));
      step(1'b1, 1'b0, 6'h3F);
      n_vec++;
      if (dut_st !== model_status() || fifo_error !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_flag: got %b want %b", dut_st, model_status());
      end
      step(1'b0, 1'b0, 6'h00);
      n_vec++;
      if (dut_st !== model_status()) begin
         n_err++;
         $display("FAIL overflow_after: got %b want %b", dut_st, model_status());
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 6'h00);
         if (m_valid) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (data_out !== exp) begin
               n_err++;
               $display("FAIL overflow_drain[%0d]: got %h want %h", i, data_out, exp);
            end
         end
      end
      n_vec++;
      if (dut_st !== model_status()) begin
         n_err++;
         $display("FAIL overflow_end: got %b want %b", dut_st, model_status());
      end
   endtask

   task automatic test_empty_rw();
      logic [5:0] exp;
      step(1'b1, 1'b1, 6'h15);
      n_vec++;
      if (dut_st !== model_status() || valid_out !== 1'b0 || fifo_error !== 1'b1) begin
         n_err++;
         $display("FAIL empty_rw_status: got %b want %b", dut_st, model_status());
      end
      step(1'b0, 1'b1, 6'h00);
      exp = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp || valid_out !== 1'b1) begin
         n_err++;
         $display("FAIL empty_rw_data: got %h/%b want %h/1", data_out, valid_out, exp);
      end
   endtask

   task automatic test_full_rw();
      logic [5:0] exp;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'(16 + i));
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 6'(42 + i));
         n_vec++;
         if (dut_st !== model_status() || Fifo_full !== 1'b1) begin
            n_err++;
            $display("FAIL full_rw_status[%0d]: got %b want %b", i, dut_st, model_status());
         end
         exp = exp_q.pop_front();
         n_vec++;
         if (data_out !== exp) begin
            n_err++;
            $display("FAIL full_rw_data[%0d]: got %h want %h", i, data_out, exp);
         end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 6'h00);
         exp = exp_q.pop_front();
         n_vec++;
         if (data_out !== exp) begin
            n_err++;
            $display("FAIL full_rw_drain[%0d]: got %h want %h", i, data_out, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'(33 + i));
      step(1'b0, 1'b1, 6'h00);
      void'(exp_q.pop_front());
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (dut_st !== 7'b0101000 || data_out !== 6'h00) begin
         n_err++;
         $display("FAIL reset_mid: got %b/%h want %b/00", dut_st, data_out, 7'b0101000);
      end
      release_reset();
      step(1'b0, 1'b1, 6'h00);
      n_vec++;
      if (dut_st !== model_status() || fifo_error !== 1'b1 || data_out !== 6'h00) begin
         n_err++;
         $display("FAIL reset_mid_underflow: got %b/%h want %b/00", dut_st, data_out, model_status());
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp;
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
         n_vec++;
         if (dut_st !== model_status()) begin
            n_err++;
            $display("FAIL b2b_status[%0d]: got %b want %b", i, dut_st, model_status());
         end
         if (m_valid) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (data_out !== exp) begin
               n_err++;
               $display("FAIL b2b_data[%0d]: got %h want %h", i, data_out, exp);
            end
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      write   = 1'b0;
      read    = 1'b0;
      data_in = 6'h00;
      model_reset();
      test_reset();
      test_fill_drain();
      test_overflow();
      test_empty_rw();
      test_full_rw();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
